// File: rtl/result_display_scanner.sv
// result_display_scanner: debounced select/hold capture of V0/V1 shown as 8 multiplexed hex digits
module result_display_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CNT = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] V0,
  input  logic [31:0] V1,
  input  logic        BtnSel,
  input  logic        BtnHold,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        SelLed
);
  localparam logic [19:0] PRE_LAST = 20'(REFRESH_DIV - 1);
  localparam logic [23:0] DB_LAST  = 24'(DEBOUNCE_CNT - 1);
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [1:0]  btnRaw, sync1, sync2, stable, accept, pulse;
  logic [23:0] dbCnt [2];
  logic        sel, hold;
  logic [31:0] snapshot;
  logic [19:0] pre;
  logic [2:0]  idx;
  assign btnRaw = {BtnHold, BtnSel};
  assign SelLed = sel;
  // a differing synced level is accepted once it has persisted for the full debounce window
  always_comb begin
    accept = '0;
    for (int i = 0; i < 2; i++) accept[i] = (sync2[i] != stable[i]) && (dbCnt[i] == DB_LAST);
    pulse = accept & sync2;
  end
  // per-button synchronizer and debounce counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      for (int i = 0; i < 2; i++) dbCnt[i] <= '0;
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        stable[i] <= accept[i] ? sync2[i] : stable[i];
        dbCnt[i] <= (sync2[i] == stable[i] || accept[i]) ? '0 : dbCnt[i] + 24'd1;
      end
    end
  end
  // control toggles, snapshot capture, digit scan and registered display drive
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel <= 1'b0;
      hold <= 1'b0;
      snapshot <= '0;
      pre <= '0;
      idx <= '0;
      An <= 8'hFF;
      Seg <= 7'h7F;
      Dp <= 1'b1;
    end else begin
      sel <= sel ^ pulse[0];
      hold <= hold ^ pulse[1];
      snapshot <= hold ? snapshot : (sel ? V1 : V0);
      pre <= (pre == PRE_LAST) ? '0 : pre + 20'd1;
      idx <= idx + 3'(pre == PRE_LAST);
      An <= ~(8'b1 << idx);
      Seg <= SEG_LUT[snapshot[{idx, 2'b00} +: 4]];
      Dp <= !(idx == 3'd0 && hold);
    end
  end
endmodule
